// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes,
// memory back-pressure freeze, controlled halt/drain and memory-timeout fault.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   IF_ID_RegS1/RegS2           decode-stage source registers
//   IF_ID_uses_rs1/rs2          decode instruction reads rs1/rs2
//   IF_ID_is_store              decode instruction is a store
//   ID_EX_MemRead, ID_EX_RegD   EX-stage load flag and destination
//   EX_branch_taken             EX branch resolved taken
//   mem_req, mem_ready          MEM-stage access handshake
//   halt_req                    level halt request
//   pc_write, IF_ID_write       PC / IF-ID load enables
//   IF_ID_flush, ID_EX_bubble   NOP insertion controls
//   EX_MEM_hold                 freeze whole pipeline
//   halted, fault               status (fault is sticky)
//   stall_count                 saturating RUN stall-cycle counter
module hazard_controller #(
    parameter int REG_W       = 3,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IF_ID_RegS1,
    input  logic [REG_W-1:0] IF_ID_RegS2,
    input  logic             IF_ID_uses_rs1,
    input  logic             IF_ID_uses_rs2,
    input  logic             IF_ID_is_store,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_RegD,
    input  logic             EX_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_hold,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic [1:0]       r_drain_cnt;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_mem_stall;
    logic w_load_use;
    logic w_timeout;
    logic w_halt_entry;
    logic w_stall_inc;

    assign w_mem_stall = mem_req & ~mem_ready;

    // Store data (rs2) is forwarded in MEM, so it never forces a stall.
    assign w_load_use = ID_EX_MemRead &
        ((IF_ID_uses_rs1 & (IF_ID_RegS1 == ID_EX_RegD)) |
         (IF_ID_uses_rs2 & ~IF_ID_is_store & (IF_ID_RegS2 == ID_EX_RegD)));

    assign w_timeout = w_mem_stall &&
        (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1));

    assign w_halt_entry = (r_state == S_RUN) & ~w_mem_stall &
        ~EX_branch_taken & ~w_load_use & halt_req;

    // Halt entry also drops pc_write but is not a hazard stall.
    assign w_stall_inc = (r_state == S_RUN) &
        (w_mem_stall | (~EX_branch_taken & w_load_use));

    assign stall_count = r_stall_count;

    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        EX_MEM_hold  = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        EX_MEM_hold = 1'b1;
                        pc_write    = 1'b0;
                        IF_ID_write = 1'b0;
                    end else if (EX_branch_taken) begin
                        IF_ID_flush  = 1'b1;
                        ID_EX_bubble = 1'b1;
                    end else if (w_load_use) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                    end else if (halt_req) begin
                        pc_write    = 1'b0;
                        IF_ID_flush = 1'b1;
                    end
                end
                S_DRAIN: begin
                    pc_write    = 1'b0;
                    IF_ID_flush = 1'b1;
                    if (w_mem_stall) begin
                        EX_MEM_hold = 1'b1;
                        IF_ID_write = 1'b0;
                    end
                end
                S_HALTED: begin
                    pc_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    IF_ID_flush  = 1'b1;
                    ID_EX_bubble = 1'b1;
                    halted       = 1'b1;
                end
                default: begin
                    pc_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    IF_ID_flush  = 1'b1;
                    ID_EX_bubble = 1'b1;
                    fault        = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_drain_cnt   <= 2'd0;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_mem_stall &&
                (r_state == S_RUN || r_state == S_DRAIN))
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;

            if (w_stall_inc && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;

            case (r_state)
                S_RUN: begin
                    if (w_timeout) begin
                        r_state <= S_FAULT;
                    end else if (w_halt_entry) begin
                        r_drain_cnt <= 2'd3;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_timeout) begin
                        r_state <= S_FAULT;
                    end else if (!w_mem_stall) begin
                        r_drain_cnt <= r_drain_cnt - 2'd1;
                        if (r_drain_cnt == 2'd1)
                            r_state <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (!halt_req)
                        r_state <= S_RUN;
                end
                default: r_state <= S_FAULT;
            endcase
        end
    end

endmodule
